// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    localparam int W32        = 32;
    localparam int OP_DIV_BIT = 2;

    function automatic logic signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_special.sv
// Divide-by-zero and signed-overflow detection with the architectural
// result for those cases, evaluated on the effective (word or full) operands.
module muldiv_special
    import muldiv_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         word,
    input  muldiv_op_e   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         special,
    output logic [N-1:0] value
);

    logic [N-1:0] dividend;
    logic         div_zero;
    logic         overflow;
    logic         is_signed;
    logic         is_rem;

    always_comb begin
        is_signed = (op == OP_DIV) || (op == OP_REM);
        is_rem    = (op == OP_REM) || (op == OP_REMU);
        if (word) begin
            dividend = N'($signed(a[W32-1:0]));
            div_zero = (b[W32-1:0] == '0);
            overflow = is_signed && (a[W32-1:0] == 32'h8000_0000)
                       && (b[W32-1:0] == '1);
        end else begin
            dividend = a;
            div_zero = (b == '0);
            overflow = is_signed && (a == {1'b1, {(N-1){1'b0}}})
                       && (b == '1);
        end
        special = op[OP_DIV_BIT] && (div_zero || overflow);
        if (div_zero) begin
            value = is_rem ? dividend : '1;
        end else begin
            value = is_rem ? '0 : dividend;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/ready/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   op,
    input  logic         word,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [4:0]   rd_in,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   rd_out
);

    localparam int CW = 7;

    muldiv_state_e  state;
    muldiv_state_e  state_n;
    muldiv_op_e     op_q;
    logic           word_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   opa;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic           neg_s;
    logic           neg_r;
    logic [CW-1:0]  cnt;

    logic           special;
    logic [N-1:0]   special_value;
    logic           is_div;

    logic [N-1:0]   a_ext;
    logic [N-1:0]   b_ext;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           a_neg;
    logic           b_neg;

    logic [N:0]     rem_sh;
    logic [N-1:0]   rem_sub;
    logic           rem_ge;

    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   full;
    logic [N-1:0]   fixed;

    assign is_div = op_q[OP_DIV_BIT];
    assign ready  = (state == S_IDLE);
    assign done   = (state == S_DONE);

    muldiv_special #(.N(N)) u_special (
        .word    (word_q),
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .special (special),
        .value   (special_value)
    );

    // Operand conditioning: width select, extension, magnitude.
    always_comb begin
        if (word_q) begin
            if (signed_a(op_q)) a_ext = N'($signed(a_q[W32-1:0]));
            else                a_ext = N'(a_q[W32-1:0]);
            if (signed_b(op_q)) b_ext = N'($signed(b_q[W32-1:0]));
            else                b_ext = N'(b_q[W32-1:0]);
        end else begin
            a_ext = a_q;
            b_ext = b_q;
        end
        a_neg = signed_a(op_q) && a_ext[N-1];
        b_neg = signed_b(op_q) && b_ext[N-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
    end

    always_comb begin
        rem_sh  = {acc[N-1:0], opa[N-1]};
        rem_ge  = (rem_sh >= {1'b0, mcand[N-1:0]});
        rem_sub = rem_sh[N-1:0] - mcand[N-1:0];
    end

    always_comb begin
        prod = neg_s ? -acc : acc;
        quo  = neg_s ? -opa : opa;
        rem  = neg_r ? -acc[N-1:0] : acc[N-1:0];
        unique case (op_q)
            OP_MUL:                       full = prod[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: full = word_q ? prod[N-1:0]
                                                        : prod[2*N-1:N];
            OP_DIV, OP_DIVU:              full = quo;
            default:                      full = rem;
        endcase
        if (word_q) fixed = N'($signed(full[W32-1:0]));
        else        fixed = full;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (start) state_n = S_PREP;
            S_PREP: state_n = (is_div && special) ? S_DONE : S_ITER;
            S_ITER: if (cnt == CW'(1)) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_MUL;
            word_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rd_out <= '0;
            opa    <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg_s  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (!flush) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= muldiv_op_e'(op);
                        word_q <= (N == 64) && word;
                        a_q    <= rs1_data;
                        b_q    <= rs2_data;
                        rd_out <= rd_in;
                    end
                end
                S_PREP: begin
                    neg_s <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= word_q ? CW'(W32) : CW'(N);
                    acc   <= '0;
                    mcand <= {{N{1'b0}}, b_mag};
                    if (is_div) begin
                        // Align the word dividend so its MSB is shifted out first.
                        opa <= word_q ? (a_mag << W32) : a_mag;
                        if (special) result <= special_value;
                    end else begin
                        opa <= a_mag;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= {{N{1'b0}},
                                rem_ge ? rem_sub : rem_sh[N-1:0]};
                        opa <= {opa[N-2:0], rem_ge};
                    end else begin
                        if (opa[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        opa   <= opa >> 1;
                    end
                end
                S_FIX: result <= fixed;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;
    localparam logic [63:0] MINV  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic        word;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [4:0]  rd_in;
    logic        ready;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit track = 1'b1;
    logic [63:0] last_res = '0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          c0;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;

    muldiv_unit #(.N(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .word     (word),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32;
        logic [31:0]  b32;
        logic [31:0]  r32;
        logic [63:0]  r;
        logic         ovf32;
        logic         ovf64;
        a32   = a[31:0];
        b32   = b[31:0];
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        ovf64 = (a == MINV) && (b == ONES);
        r32   = '0;
        r     = '0;
        p     = '0;
        if (w) begin
            case (o)
                DIV: begin
                    if (b32 == 0) r32 = '1;
                    else if (ovf32) r32 = a32;
                    else r32 = $signed(a32) / $signed(b32);
                end
                DIVU: begin
                    if (b32 == 0) r32 = '1;
                    else r32 = a32 / b32;
                end
                REM: begin
                    if (b32 == 0) r32 = a32;
                    else if (ovf32) r32 = '0;
                    else r32 = $signed(a32) % $signed(b32);
                end
                REMU: begin
                    if (b32 == 0) r32 = a32;
                    else r32 = a32 % b32;
                end
                default: r32 = a32 * b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                MUL: r = a * b;
                MULH: begin
                    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                    r = p[127:64];
                end
                MULHSU: begin
                    p = {{64{a[63]}}, a} * {64'd0, b};
                    r = p[127:64];
                end
                MULHU: begin
                    p = {64'd0, a} * {64'd0, b};
                    r = p[127:64];
                end
                DIV: begin
                    if (b == 0) r = '1;
                    else if (ovf64) r = a;
                    else r = $signed(a) / $signed(b);
                end
                DIVU: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                REM: begin
                    if (b == 0) r = a;
                    else if (ovf64) r = '0;
                    else r = $signed(a) % $signed(b);
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    function automatic int lat_model(input logic [2:0] o, input logic w,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        logic z;
        logic ovf;
        if (w) begin
            z   = (b[31:0] == 0);
            ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        end else begin
            z   = (b == 0);
            ovf = (a == MINV) && (b == ONES);
        end
        if (o[2] && (z || (!o[0] && ovf))) return 1;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: v = '0;
            1: v = ONES;
            2: v = MINV;
            3: v = 64'($urandom_range(0, 20));
            4: v = -64'($urandom_range(1, 20));
            5: v = {v[63:32], 32'h8000_0000};
            6: v = {v[63:32], 32'hFFFF_FFFF};
            default: ;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (track) check("ready", 64'(ready), 64'(q.size() == 0));
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("rd_out", 64'(rd_out), 64'(e.rd));
                    if (e.lat >= 0) check("latency", 64'(cyc - e.c0), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] er,
                         input int el);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_wait", 64'(ready), 64'd1);
        op       = o;
        word     = w;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q.push_back('{er, rd, cyc, el});
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        last_res = er;
    endtask

    task automatic lit(input string name, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] want,
                       input int lat);
        check({"model_", name}, model(o, w, a, b), want);
        if (lat >= 0) check({"latmodel_", name}, 64'(lat_model(o, w, a, b)), 64'(lat));
        issue(o, w, a, b, rd, want, lat);
    endtask

    initial begin
        logic [2:0]  o;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        reset    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = '0;
        word     = 1'b0;
        rs1_data = '0;
        rs2_data = '0;
        rd_in    = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        lit("mul", MUL, 0, 64'd7, -64'd3, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        lit("mulhu", MULHU, 0, ONES, ONES, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        lit("mulh_m1", MULH, 0, ONES, ONES, 5'd5, 64'd0, 66);
        lit("mulh_min", MULH, 0, MINV, MINV, 5'd6, 64'h4000_0000_0000_0000, 66);
        lit("mulhsu", MULHSU, 0, ONES, 64'd2, 5'd7, ONES, 66);
        lit("div", DIV, 0, -64'd20, 64'd6, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        lit("rem", REM, 0, -64'd20, 64'd6, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        lit("divu_z", DIVU, 0, 64'h1234, 64'd0, 5'd10, ONES, 1);
        lit("remu_z", REMU, 0, 64'h1234, 64'd0, 5'd11, 64'h1234, 1);
        lit("div_ovf", DIV, 0, MINV, ONES, 5'd12, MINV, 1);
        lit("rem_ovf", REM, 0, MINV, ONES, 5'd13, 64'd0, 1);
        lit("divw_ovf", DIV, 1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
            5'd14, 64'hFFFF_FFFF_8000_0000, -1);
        lit("divw", DIV, 1, -64'd7, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        lit("remw", REM, 1, -64'd7, 64'd2, 5'd16, ONES, 34);
        lit("mulw", MUL, 1, 64'h0000_000A_7FFF_FFFF, 64'd2, 5'd17,
            64'hFFFF_FFFF_FFFF_FFFE, 34);
        lit("divuw", DIVU, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd18,
            64'h0000_0000_7FFF_FFFF, 34);

        // Flush on the tenth edge of a multiply.
        track = 1'b0;
        @(negedge clk);
        op = MUL; word = 1'b0; rs1_data = 64'd99; rs2_data = 64'd5;
        rd_in = 5'd21; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_result", result, last_res);
        track = 1'b1;
        repeat (80) @(negedge clk);
        check("flush_result_hold", result, last_res);

        // Start together with flush must not be accepted.
        @(negedge clk);
        op = MUL; rs1_data = 64'd3; rs2_data = 64'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_ready", 64'(ready), 64'd1);
        repeat (80) @(negedge clk);

        // Asynchronous reset in the middle of the iteration.
        track = 1'b0;
        @(negedge clk);
        op = DIV; rs1_data = 64'd1000; rs2_data = 64'd7; rd_in = 5'd22;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", result, 64'd0);
        check("mid_rst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        track = 1'b1;

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = rnd_operand();
            b = rnd_operand();
            issue(o, w, a, b, 5'($urandom_range(0, 31)), model(o, w, a, b),
                  lat_model(o, w, a, b));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
